run_sequencer: RTL and testbench
================================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter CNT_W, 16, width of the CycleCount counter.
REQ-002 Parameter TIMEOUT, 16'hFFFF, maximum RUN cycles without Ack before a forced finish.
REQ-003 Parameter START_LEN, 2, number of cycles CoreStart is held high (range 1..15).
REQ-004 Port Clk  input  1  clock; all state changes on posedge.
REQ-005 Port Reset  input  1  synchronous, active-high reset.
REQ-006 Port Go  input  1  run request from host; sampled only in IDLE.
REQ-007 Port Abort  input  1  cancel the current run; sampled only in START/RUN.
REQ-008 Port Ack  input  1  done flag from the processor core; sampled only in RUN.
REQ-009 Port CoreStart  output  1  start strobe driven to the core's Start input.
REQ-010 Port Busy  output  1  high while in START or RUN.
REQ-011 Port Done  output  1  one-cycle pulse at run completion (normal or timeout).
REQ-012 Port TimedOut  output  1  sticky flag; last run ended by timeout.
REQ-013 Port CycleCount  output  CNT_W  RUN cycles counted for the current or last run.
REQ-014 Port RunCount  output  8  completed runs (Done pulses) since reset.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, START, RUN and DONE; all outputs SHALL be registered or decoded from state only (Moore).
REQ-016 IDLE: Go=1 -> START at the next edge, with CycleCount cleared to 0 and TimedOut cleared to 0 on that same edge.
REQ-017 Go sampled at edge k -> CoreStart=1 from cycle k+1 for exactly START_LEN cycles, then RUN.
REQ-018 START: Ack ignored; CycleCount stays at 0.
REQ-019 RUN: CoreStart=0; each cycle with Ack=0 increments CycleCount by 1.
REQ-020 RUN with Ack=1 -> DONE; CycleCount not incremented that cycle.
REQ-021 RUN with Ack=0 and CycleCount==TIMEOUT -> DONE with TimedOut set to 1; CycleCount holds TIMEOUT and never wraps.
REQ-022 RUN: Ack=1 in the same cycle as the timeout condition -> Ack wins; TimedOut stays 0.
REQ-023 DONE: Done=1 for exactly one cycle; RunCount increments (wraps 255->0); next state IDLE.
REQ-024 Abort=1 in START or RUN -> IDLE at the next edge; CoreStart=0, no Done pulse, RunCount unchanged, CycleCount held. Abort outranks Ack and timeout in the same cycle.
REQ-025 Go outside IDLE (including in DONE) SHALL be ignored, not queued.
REQ-026 CycleCount and TimedOut SHALL hold their values in IDLE until the next accepted Go.
REQ-027 Busy=1 exactly in START and RUN; Busy and Done are never high together.

Reset
REQ-028 Reset=1 at an edge -> state IDLE; CoreStart, Busy, Done and TimedOut = 0; CycleCount = 0; RunCount = 0.
REQ-029 Reset SHALL override Go, Abort and Ack in any state, including mid-run, with no Done pulse generated.

Structure
REQ-030 A shared package run_seq_pkg SHALL hold the state enum typedef (IDLE/START/RUN/DONE) and the default constants for CNT_W, TIMEOUT and START_LEN.
REQ-031 A sub-module sat_counter (clear, enable, saturate-at-limit, parameterised width) SHALL implement CycleCount; the START_LEN timer SHALL be a local counter in the FSM.

Verification
REQ-032 Reset, Go pulse, START_LEN=2, Ack rises on the 11th RUN cycle -> CoreStart high exactly 2 cycles, Done 1 cycle, CycleCount=10, RunCount=1, TimedOut=0.
REQ-033 TIMEOUT=20, Ack held 0 -> Done after CycleCount reaches 20, TimedOut=1, CycleCount=20; next Go clears TimedOut.
REQ-034 Ack held 1 through START and into the first RUN cycle -> no early exit during START; Done with CycleCount=0.
REQ-035 Abort on RUN cycle 5, with Ack=1 in that same cycle -> IDLE, no Done, CycleCount=5 held, RunCount unchanged, Busy=0.
REQ-036 Go pulsed while Busy, then Reset asserted mid-RUN -> Go ignored; the cycle after Reset all outputs read 0 and the state is IDLE.
REQ-037 TIMEOUT=20, Ack rises in the same cycle CycleCount==20 -> Done, TimedOut=0, CycleCount=20.

Source files
------------

// File: rtl/run_seq_pkg.sv
// run_seq_pkg -- shared definitions for the run sequencer.
//   state_t        : sequencer FSM states (IDLE, START, RUN, DONE)
//   CNT_W_DEF      : default width of the RUN cycle counter
//   TIMEOUT_DEF    : default RUN cycle limit before a forced finish
//   START_LEN_DEF  : default number of cycles the core start strobe is held
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          CNT_W_DEF     = 16;
  localparam logic [15:0] TIMEOUT_DEF   = 16'hFFFF;
  localparam int          START_LEN_DEF = 2;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up-counter with synchronous clear that stops at a limit.
//   Clk     : clock
//   Reset   : synchronous active-high reset, Count -> 0
//   Clear   : synchronous clear, Count -> 0
//   Enable  : count up by one this cycle (ignored once Count == Limit)
//   Limit   : saturation value
//   Count   : current count
//   AtLimit : Count equals Limit
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             Enable,
  input  logic [WIDTH-1:0] Limit,
  output logic [WIDTH-1:0] Count,
  output logic             AtLimit
);

  assign AtLimit = (Count == Limit);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Count <= '0;
    end else if (Clear) begin
      Count <= '0;
    end else if (Enable && !AtLimit) begin
      Count <= Count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer -- launches one processor-core run per host request.
//   Clk        : clock, all state changes on posedge
//   Reset      : synchronous active-high reset
//   Go         : run request, sampled in IDLE only
//   Abort      : cancel the current run, sampled in START/RUN only
//   Ack        : core done flag, sampled in RUN only
//   CoreStart  : start strobe to the core, high for START_LEN cycles
//   Busy       : high in START and RUN
//   Done       : one-cycle completion pulse (normal finish or timeout)
//   TimedOut   : sticky, last run ended by timeout
//   CycleCount : RUN cycles without Ack for the current/last run
//   RunCount   : completed runs since reset (wraps at 255)
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int             CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_DEF),
  parameter int             START_LEN = START_LEN_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Abort,
  input  logic             Ack,
  output logic             CoreStart,
  output logic             Busy,
  output logic             Done,
  output logic             TimedOut,
  output logic [CNT_W-1:0] CycleCount,
  output logic [7:0]       RunCount
);

  state_t     state;
  state_t     stateNext;
  logic [3:0] startCnt;
  logic       startLast;
  logic       cntClear;
  logic       cntEnable;
  logic       atLimit;
  logic       setTimeout;

  assign startLast = (startCnt == 4'(START_LEN - 1));

  // The counter saturates at TIMEOUT, so CycleCount can never wrap even if
  // the FSM were to linger in RUN.
  sat_counter #(
    .WIDTH (CNT_W)
  ) uCycleCnt (
    .Clk     (Clk),
    .Reset   (Reset),
    .Clear   (cntClear),
    .Enable  (cntEnable),
    .Limit   (TIMEOUT),
    .Count   (CycleCount),
    .AtLimit (atLimit)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Priority in START/RUN: Abort, then Ack, then timeout.
  always_comb begin
    stateNext  = state;
    cntClear   = 1'b0;
    cntEnable  = 1'b0;
    setTimeout = 1'b0;
    case (state)
      IDLE: begin
        if (Go) begin
          stateNext = START;
          cntClear  = 1'b1;
        end
      end
      START: begin
        if (Abort) begin
          stateNext = IDLE;
        end else if (startLast) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        if (Abort) begin
          stateNext = IDLE;
        end else if (Ack) begin
          stateNext = DONE;
        end else if (atLimit) begin
          stateNext  = DONE;
          setTimeout = 1'b1;
        end else begin
          cntEnable = 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // startCnt restarts on every START entry because it is zero outside START.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      startCnt <= '0;
      TimedOut <= 1'b0;
      RunCount <= '0;
    end else begin
      startCnt <= (state == START) ? startCnt + 4'd1 : 4'd0;
      if (cntClear) begin
        TimedOut <= 1'b0;
      end else if (setTimeout) begin
        TimedOut <= 1'b1;
      end
      if (state == DONE) begin
        RunCount <= RunCount + 8'd1;
      end
    end
  end

  assign CoreStart = (state == START);
  assign Busy      = (state == START) || (state == RUN);
  assign Done      = (state == DONE);

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer -- directed self-checking bench for run_sequencer with a
// completion scoreboard (TIMEOUT=20, START_LEN=2).
module tb_run_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Go;
  logic        Abort;
  logic        Ack;
  logic        CoreStart;
  logic        Busy;
  logic        Done;
  logic        TimedOut;
  logic [15:0] CycleCount;
  logic [7:0]  RunCount;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] cc;
    logic        to;
    logic [7:0]  rc;
  } exp_t;

  exp_t sb[$];

  run_sequencer #(
    .CNT_W     (16),
    .TIMEOUT   (16'd20),
    .START_LEN (2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Go         (Go),
    .Abort      (Abort),
    .Ack        (Ack),
    .CoreStart  (CoreStart),
    .Busy       (Busy),
    .Done       (Done),
    .TimedOut   (TimedOut),
    .CycleCount (CycleCount),
    .RunCount   (RunCount)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Go pulse, two START cycles, ends in the first RUN cycle.
  task automatic startRun();
    Go = 1'b1;
    step();
    Go = 1'b0;
    chk("start1CoreStart", CoreStart, 1);
    chk("start1Busy", Busy, 1);
    chk("start1CycleCount", CycleCount, 0);
    chk("start1TimedOut", TimedOut, 0);
    chk("start1Done", Done, 0);
    step();
    chk("start2CoreStart", CoreStart, 1);
    chk("start2Done", Done, 0);
    chk("start2CycleCount", CycleCount, 0);
    step();
    chk("runEntryCoreStart", CoreStart, 0);
    chk("runEntryBusy", Busy, 1);
    chk("runEntryDone", Done, 0);
  endtask

  task automatic waitDone(input int maxCyc, output int n);
    n = 0;
    while (Done !== 1'b1 && n < maxCyc) begin
      step();
      n++;
    end
    chk("doneSeen", Done, 1);
  endtask

  // Called in the DONE cycle: compares against the oldest expected run.
  task automatic popCheck(output exp_t e);
    chk("sbHasEntry", sb.size() > 0, 1);
    e = '{cc: 16'hxxxx, to: 1'bx, rc: 8'hxx};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("doneCycleCount", CycleCount, e.cc);
      chk("doneTimedOut", TimedOut, e.to);
      chk("doneBusy", Busy, 0);
      chk("doneCoreStart", CoreStart, 0);
    end
  endtask

  task automatic finishRun(input exp_t e);
    step();
    chk("afterDoneDone", Done, 0);
    chk("afterDoneBusy", Busy, 0);
    chk("afterDoneRunCount", RunCount, e.rc);
  endtask

  always @(negedge Clk) begin
    if (Reset === 1'b0) chk("busyDoneExcl", Busy & Done, 0);
  end

  initial begin
    int   n;
    exp_t e;

    Reset = 1'b1;
    Go    = 1'b0;
    Abort = 1'b0;
    Ack   = 1'b0;
    step();
    step();
    chk("rstCoreStart", CoreStart, 0);
    chk("rstBusy", Busy, 0);
    chk("rstDone", Done, 0);
    chk("rstTimedOut", TimedOut, 0);
    chk("rstCycleCount", CycleCount, 0);
    chk("rstRunCount", RunCount, 0);
    Reset = 1'b0;
    step();
    chk("idleBusy", Busy, 0);

    // Normal run: Ack on the 11th RUN cycle.
    sb.push_back('{cc: 16'd10, to: 1'b0, rc: 8'd1});
    startRun();
    repeat (10) step();
    chk("run11CycleCount", CycleCount, 10);
    Ack = 1'b1;
    waitDone(3, n);
    chk("ackLatency", n, 1);
    popCheck(e);
    Ack = 1'b0;
    finishRun(e);

    // Timeout with Ack held low; Go in DONE must be ignored.
    sb.push_back('{cc: 16'd20, to: 1'b1, rc: 8'd2});
    startRun();
    waitDone(40, n);
    chk("timeoutLatency", n, 21);
    popCheck(e);
    Go = 1'b1;
    step();
    chk("goInDoneBusy", Busy, 0);
    chk("goInDoneRunCount", RunCount, e.rc);
    chk("goInDoneDone", Done, 0);
    Go = 1'b0;
    step();
    chk("goNotQueuedBusy", Busy, 0);
    chk("idleHoldTimedOut", TimedOut, 1);
    chk("idleHoldCycleCount", CycleCount, 20);

    // Ack held through START: no early exit, finish with zero count.
    Ack = 1'b1;
    sb.push_back('{cc: 16'd0, to: 1'b0, rc: 8'd3});
    startRun();
    waitDone(3, n);
    chk("ackEarlyLatency", n, 1);
    popCheck(e);
    Ack = 1'b0;
    finishRun(e);

    // Ack coincides with the timeout condition: Ack wins.
    sb.push_back('{cc: 16'd20, to: 1'b0, rc: 8'd4});
    startRun();
    repeat (20) step();
    chk("atLimitCycleCount", CycleCount, 20);
    chk("atLimitDone", Done, 0);
    chk("atLimitBusy", Busy, 1);
    Ack = 1'b1;
    waitDone(3, n);
    chk("ackVsTimeoutLatency", n, 1);
    popCheck(e);
    Ack = 1'b0;
    finishRun(e);

    // Abort together with Ack when CycleCount reads 5.
    startRun();
    repeat (5) step();
    chk("preAbortCycleCount", CycleCount, 5);
    Abort = 1'b1;
    Ack   = 1'b1;
    step();
    Abort = 1'b0;
    Ack   = 1'b0;
    chk("abortBusy", Busy, 0);
    chk("abortDone", Done, 0);
    chk("abortCoreStart", CoreStart, 0);
    chk("abortCycleCount", CycleCount, 5);
    chk("abortRunCount", RunCount, 4);
    step();
    chk("postAbortDone", Done, 0);
    chk("postAbortCycleCount", CycleCount, 5);
    chk("postAbortRunCount", RunCount, 4);

    // Go held while busy, then Reset mid-RUN.
    Go = 1'b1;
    step();
    chk("goHeldStart1", CoreStart, 1);
    step();
    chk("goHeldStart2", CoreStart, 1);
    step();
    chk("goHeldRunCoreStart", CoreStart, 0);
    chk("goHeldRunBusy", Busy, 1);
    step();
    chk("goHeldRun2Busy", Busy, 1);
    chk("goHeldRun2CycleCount", CycleCount, 1);
    Go = 1'b0;
    step();
    chk("midRunCycleCount", CycleCount, 2);
    Reset = 1'b1;
    Ack   = 1'b1;
    Go    = 1'b1;
    step();
    chk("midRstCoreStart", CoreStart, 0);
    chk("midRstBusy", Busy, 0);
    chk("midRstDone", Done, 0);
    chk("midRstTimedOut", TimedOut, 0);
    chk("midRstCycleCount", CycleCount, 0);
    chk("midRstRunCount", RunCount, 0);
    Reset = 1'b0;
    Ack   = 1'b0;
    Go    = 1'b0;
    step();
    chk("postRstBusy", Busy, 0);
    chk("postRstDone", Done, 0);
    chk("postRstCoreStart", CoreStart, 0);
    chk("postRstRunCount", RunCount, 0);

    chk("sbDrained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
